// File: rtl/switch_word_entry_pkg.sv
// Shared constants for the operator word-entry path: FSM encodings,
// nibble geometry and the default debounce interval.
package switch_word_entry_pkg;

  localparam logic ST_ENTRY = 1'b0;
  localparam logic ST_HOLD  = 1'b1;

  localparam int NIBBLE_W         = 4;
  localparam int DEFAULT_DEBOUNCE = 50000;

  function automatic int nibbles_of(input int word_width);
    return word_width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/switch_word_entry_key_debouncer.sv
// One pushbutton channel: 2-flop synchroniser, stable-level debouncer and a
// one-cycle press pulse on each debounced release-to-press transition.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // armed_q blocks presses until the key has been seen released and stable
  // after reset, so a key held through reset never produces a pulse.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = cnt_q;
    clean_d = clean_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_MAX) begin
        clean_d = sync2_q;
        cnt_d   = '0;
        press_d = armed_q & ~sync2_q;
        if (sync2_q) armed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!armed_q && sync2_q) begin
      if (cnt_q == CNT_MAX) begin
        armed_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset values model a released key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      clean_q <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      armed_q <= armed_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/switch_word_entry.sv
// Operator input path: debounced ENTER/CLEAR keys assemble a word from switch
// nibbles (MSB first) and hand it to the CPU over a valid/ready handshake.
module switch_word_entry
  import switch_word_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int WORD_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NIBBLE_W-1:0]   sw_nibble,
  input  logic                  key_n_enter,
  input  logic                  key_n_clear,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [WORD_WIDTH-1:0] entry_value,
  output logic [2:0]            nibble_count
);

  localparam int NIBBLES = nibbles_of(WORD_WIDTH);

  logic                  enter_pulse, clear_pulse;
  logic [NIBBLE_W-1:0]   sw_s1_q, sw_s2_q;
  logic                  state_q, state_d;
  logic [WORD_WIDTH-1:0] entry_q, entry_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic [2:0]            count_q, count_d;
  logic [WORD_WIDTH-1:0] entry_shift;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_n_enter),
    .press_o (enter_pulse)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_n_clear),
    .press_o (clear_pulse)
  );

  assign entry_shift = {entry_q[WORD_WIDTH-NIBBLE_W-1:0], sw_s2_q};

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    word_d  = word_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      ST_ENTRY: begin
        if (clear_pulse) begin
          entry_d = '0;
          count_d = '0;
        end else if (enter_pulse) begin
          entry_d = entry_shift;
          count_d = count_q + 3'd1;
          if (count_q == 3'(NIBBLES - 1)) begin
            word_d  = entry_shift;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      default: begin
        // Keys are ignored here; only the transfer leaves HOLD.
        if (word_ready) begin
          valid_d = 1'b0;
          entry_d = '0;
          count_d = '0;
          state_d = ST_ENTRY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      state_q <= ST_ENTRY;
      entry_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      sw_s1_q <= sw_nibble;
      sw_s2_q <= sw_s1_q;
      state_q <= state_d;
      entry_q <= entry_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign word_out     = word_q;
  assign word_valid   = valid_q;
  assign entry_value  = entry_q;
  assign nibble_count = count_q;

endmodule

// File: tb/tb_switch_word_entry.sv
// Directed bench for switch_word_entry with a short debounce interval.
module tb_switch_word_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw_nibble;
  logic        key_n_enter, key_n_clear;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] entry_value;
  logic [2:0]  nibble_count;

  int n_pass = 0;
  int n_total = 0;

  switch_word_entry #(.DEBOUNCE_CYCLES(4), .WORD_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_nibble    (sw_nibble),
    .key_n_enter  (key_n_enter),
    .key_n_clear  (key_n_clear),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .entry_value  (entry_value),
    .nibble_count (nibble_count)
  );

  always #5 clk = ~clk;

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic press_enter(input logic [3:0] nib);
    sw_nibble   = nib;
    key_n_enter = 1'b0;
    ticks(10);
    key_n_enter = 1'b1;
    ticks(10);
  endtask

  task automatic press_clear();
    key_n_clear = 1'b0;
    ticks(10);
    key_n_clear = 1'b1;
    ticks(10);
  endtask

  initial begin
    rst = 1'b1;
    sw_nibble = 4'h0;
    key_n_enter = 1'b1;
    key_n_clear = 1'b1;
    word_ready = 1'b0;
    ticks(3);
    check("reset_valid", 32'(word_valid), 32'h0);
    check("reset_word", 32'(word_out), 32'h0);
    check("reset_count", 32'(nibble_count), 32'h0);
    rst = 1'b0;
    ticks(10);
    check("idle_entry", 32'(entry_value), 32'h0);

    // Case 1: A,B,C,D with ready low; 4th press timed exactly.
    press_enter(4'hA);
    check("c1_after_a", 32'(entry_value), 32'h000A);
    press_enter(4'hB);
    press_enter(4'hC);
    check("c1_after_c", 32'(entry_value), 32'h0ABC);
    sw_nibble   = 4'hD;
    key_n_enter = 1'b0;
    ticks(6);
    check("c1_pulse_cycle_valid", 32'(word_valid), 32'h0);
    check("c1_pulse_cycle_count", 32'(nibble_count), 32'd3);
    ticks(1);
    check("c1_valid", 32'(word_valid), 32'h1);
    check("c1_word", 32'(word_out), 32'hABCD);
    check("c1_count", 32'(nibble_count), 32'd4);
    key_n_enter = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ticks(1);
      check("c1_hold_word", 32'(word_out), 32'hABCD);
    end
    check("c1_hold_valid", 32'(word_valid), 32'h1);

    // Case 2: one-cycle ready pulse completes the transfer.
    word_ready = 1'b1;
    ticks(1);
    word_ready = 1'b0;
    check("c2_valid", 32'(word_valid), 32'h0);
    check("c2_count", 32'(nibble_count), 32'd0);
    check("c2_entry", 32'(entry_value), 32'h0);
    check("c2_word_kept", 32'(word_out), 32'hABCD);

    // Case 3: short glitch, then a bounce train settling low.
    sw_nibble   = 4'h5;
    key_n_enter = 1'b0;
    ticks(2);
    key_n_enter = 1'b1;
    ticks(10);
    check("c3_glitch_count", 32'(nibble_count), 32'd0);
    key_n_enter = 1'b0; ticks(3);
    key_n_enter = 1'b1; ticks(1);
    key_n_enter = 1'b0; ticks(2);
    key_n_enter = 1'b1; ticks(1);
    key_n_enter = 1'b0; ticks(10);
    key_n_enter = 1'b1; ticks(10);
    check("c3_count", 32'(nibble_count), 32'd1);
    check("c3_entry", 32'(entry_value), 32'h0005);

    // Case 4: 3,7 then CLEAR; then simultaneous ENTER+CLEAR.
    press_clear();
    check("c4_pre_clear", 32'(nibble_count), 32'd0);
    press_enter(4'h3);
    check("c4_entry_3", 32'(entry_value), 32'h0003);
    press_enter(4'h7);
    check("c4_entry_37", 32'(entry_value), 32'h0037);
    check("c4_count_2", 32'(nibble_count), 32'd2);
    press_clear();
    check("c4_entry_clr", 32'(entry_value), 32'h0000);
    check("c4_count_clr", 32'(nibble_count), 32'd0);
    sw_nibble   = 4'h9;
    key_n_enter = 1'b0;
    key_n_clear = 1'b0;
    ticks(10);
    key_n_enter = 1'b1;
    key_n_clear = 1'b1;
    ticks(10);
    check("c4_both_count", 32'(nibble_count), 32'd0);
    check("c4_both_entry", 32'(entry_value), 32'h0000);

    // Case 5: keys ignored in HOLD.
    press_enter(4'h1);
    press_enter(4'h2);
    press_enter(4'h3);
    press_enter(4'h4);
    check("c5_word", 32'(word_out), 32'h1234);
    press_enter(4'hF);
    press_clear();
    check("c5_word_held", 32'(word_out), 32'h1234);
    check("c5_valid_held", 32'(word_valid), 32'h1);
    check("c5_count_held", 32'(nibble_count), 32'd4);
    word_ready = 1'b1;
    ticks(1);
    check("c5_xfer_valid", 32'(word_valid), 32'h0);
    check("c5_xfer_count", 32'(nibble_count), 32'd0);

    // Case 5b: ready already high when valid rises; ready ignored in ENTRY.
    press_enter(4'h9);
    press_enter(4'h8);
    press_enter(4'h7);
    check("c5b_entry_ready_ignored", 32'(nibble_count), 32'd3);
    sw_nibble   = 4'h6;
    key_n_enter = 1'b0;
    ticks(7);
    check("c5b_first_valid", 32'(word_valid), 32'h1);
    check("c5b_word", 32'(word_out), 32'h9876);
    ticks(1);
    check("c5b_xfer_next", 32'(word_valid), 32'h0);
    key_n_enter = 1'b1;
    word_ready  = 1'b0;
    ticks(10);

    // Case 6: async reset mid-cycle after two nibbles, keys held low through release.
    press_enter(4'h5);
    press_enter(4'h6);
    check("c6_pre_entry", 32'(entry_value), 32'h0056);
    #3;
    rst = 1'b1;
    #1;
    check("c6_rst_entry", 32'(entry_value), 32'h0);
    check("c6_rst_count", 32'(nibble_count), 32'h0);
    check("c6_rst_word", 32'(word_out), 32'h0);
    check("c6_rst_valid", 32'(word_valid), 32'h0);
    key_n_enter = 1'b0;
    key_n_clear = 1'b0;
    sw_nibble   = 4'hC;
    ticks(3);
    rst = 1'b0;
    ticks(20);
    check("c6_held_count", 32'(nibble_count), 32'd0);
    check("c6_held_entry", 32'(entry_value), 32'h0);
    key_n_enter = 1'b1;
    key_n_clear = 1'b1;
    ticks(15);
    check("c6_release_count", 32'(nibble_count), 32'd0);
    press_enter(4'hA);
    check("c6_new_count", 32'(nibble_count), 32'd1);
    check("c6_new_entry", 32'(entry_value), 32'h000A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
